// File: rtl/cache_pkg.sv
// Shared types for the set-associative write-back cache: controller states
// and the helper that sizes per-way age fields.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TAG       = 3'd1,
    WB        = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4,
    RESP      = 3'd5
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'd1 << i) < value) ? i + 1 : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_lru_age.sv
// Next-age vector for one set: the accessed way becomes MRU (age 0) and every
// way that was younger than it ages by one, so ages stay a permutation.
module cache_lru_age #(
  parameter int WAYS  = 2,
  parameter int AGE_W = 1
) (
  input  logic [WAYS*AGE_W-1:0] age_i,
  input  logic [AGE_W-1:0]      way_i,
  output logic [WAYS*AGE_W-1:0] age_o
);

  logic [AGE_W-1:0] old_age_s;
  logic [AGE_W-1:0] cur_age_s;

  always_comb begin
    age_o     = age_i;
    cur_age_s = '0;
    old_age_s = age_i[int'(way_i)*AGE_W +: AGE_W];
    for (int w = 0; w < WAYS; w++) begin
      cur_age_s = age_i[w*AGE_W +: AGE_W];
      if (AGE_W'(w) == way_i) begin
        age_o[w*AGE_W +: AGE_W] = '0;
      end else if (cur_age_s < old_age_s) begin
        age_o[w*AGE_W +: AGE_W] = cur_age_s + AGE_W'(1);
      end else begin
        age_o[w*AGE_W +: AGE_W] = cur_age_s;
      end
    end
  end

endmodule

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back/write-allocate cache, one word per line.
// Optional statistics counters are built only when CACHE_STATS_EN is defined.
module cache_assoc_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 5,
  parameter int SET_BITS = 1,
  parameter int WAYS     = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
  output logic [15:0]       wb_count
);

  localparam int TAG_W = ADDR_W - SET_BITS;
  localparam int SETS  = 1 << SET_BITS;
  localparam int AGE_W = clog2(WAYS);

  state_e state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [AGE_W-1:0]  victim_q, victim_d;

  logic                  valid_q [SETS][WAYS];
  logic                  valid_d [SETS][WAYS];
  logic                  dirty_q [SETS][WAYS];
  logic                  dirty_d [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]      tag_d   [SETS][WAYS];
  logic [DATA_W-1:0]     data_q  [SETS][WAYS];
  logic [DATA_W-1:0]     data_d  [SETS][WAYS];
  logic [WAYS*AGE_W-1:0] age_q   [SETS];
  logic [WAYS*AGE_W-1:0] age_d   [SETS];

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_hit_q, resp_hit_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [SET_BITS-1:0]   set_s;
  logic [TAG_W-1:0]      tag_s;
  logic [WAYS-1:0]       match_s;
  logic                  hit_s, inv_any_s;
  logic [AGE_W-1:0]      hit_way_s, inv_way_s, lru_way_s, victim_s, acc_way_s;
  logic                  upd_en_s, upd_dirty_s, clean_en_s, touch_en_s;
  logic [DATA_W-1:0]     upd_data_s;
  logic [WAYS*AGE_W-1:0] new_age_s;

  function automatic logic [WAYS*AGE_W-1:0] init_ages();
    logic [WAYS*AGE_W-1:0] v;
    v = '0;
    for (int w = 0; w < WAYS; w++) begin
      v[w*AGE_W +: AGE_W] = AGE_W'(w);
    end
    return v;
  endfunction

  assign set_s = addr_q[SET_BITS-1:0];
  assign tag_s = addr_q[ADDR_W-1:SET_BITS];

  // Hit detection and victim choice: lowest invalid way, otherwise the LRU way.
  always_comb begin
    match_s   = '0;
    hit_way_s = '0;
    inv_way_s = '0;
    lru_way_s = '0;
    inv_any_s = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match_s[w] = valid_q[set_s][w] && (tag_q[set_s][w] == tag_s);
      hit_way_s  = match_s[w] ? AGE_W'(w) : hit_way_s;
      inv_way_s  = !valid_q[set_s][w] ? AGE_W'(w) : inv_way_s;
      inv_any_s  = inv_any_s | !valid_q[set_s][w];
      lru_way_s  = (age_q[set_s][w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) ? AGE_W'(w) : lru_way_s;
    end
    hit_s    = |match_s;
    victim_s = inv_any_s ? inv_way_s : lru_way_s;
  end

  cache_lru_age #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_lru_age (
    .age_i (age_q[set_s]),
    .way_i (acc_way_s),
    .age_o (new_age_s)
  );

  // Controller: next state, line-update requests and next registered outputs.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    victim_d     = victim_q;
    resp_rdata_d = resp_rdata_q;
    resp_hit_d   = resp_hit_q;
    upd_en_s     = 1'b0;
    upd_dirty_s  = 1'b0;
    upd_data_s   = '0;
    clean_en_s   = 1'b0;
    touch_en_s   = 1'b0;
    acc_way_s    = victim_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = TAG;
        end else begin
          state_d = IDLE;
        end
      end
      TAG: begin
        if (hit_s) begin
          touch_en_s = 1'b1;
          acc_way_s  = hit_way_s;
          resp_hit_d = 1'b1;
          state_d    = RESP;
          if (wr_q) begin
            upd_en_s     = 1'b1;
            upd_dirty_s  = 1'b1;
            upd_data_s   = wdata_q;
            resp_rdata_d = wdata_q;
          end else begin
            resp_rdata_d = data_q[set_s][hit_way_s];
          end
        end else begin
          victim_d   = victim_s;
          acc_way_s  = victim_s;
          resp_hit_d = 1'b0;
          if (valid_q[set_s][victim_s] && dirty_q[set_s][victim_s]) begin
            state_d = WB;
          end else if (!wr_q) begin
            state_d = FILL_REQ;
          end else begin
            // A line is one word, so a write miss installs without a refill.
            upd_en_s     = 1'b1;
            touch_en_s   = 1'b1;
            upd_dirty_s  = 1'b1;
            upd_data_s   = wdata_q;
            resp_rdata_d = wdata_q;
            state_d      = RESP;
          end
        end
      end
      WB: begin
        if (mem_req_ready) begin
          if (wr_q) begin
            upd_en_s     = 1'b1;
            touch_en_s   = 1'b1;
            upd_dirty_s  = 1'b1;
            upd_data_s   = wdata_q;
            resp_rdata_d = wdata_q;
            state_d      = RESP;
          end else begin
            clean_en_s = 1'b1;
            state_d    = FILL_REQ;
          end
        end else begin
          state_d = WB;
        end
      end
      FILL_REQ: begin
        state_d = mem_req_ready ? FILL_WAIT : FILL_REQ;
      end
      FILL_WAIT: begin
        if (mem_rvalid) begin
          upd_en_s     = 1'b1;
          touch_en_s   = 1'b1;
          upd_dirty_s  = 1'b0;
          upd_data_s   = mem_rdata;
          resp_rdata_d = mem_rdata;
          state_d      = RESP;
        end else begin
          state_d = FILL_WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d     = (state_d == IDLE);
    resp_valid_d    = (state_d == RESP);
    mem_req_valid_d = (state_d == WB) || (state_d == FILL_REQ);
    mem_write_d     = (state_d == WB);
    case (state_d)
      WB: begin
        mem_addr_d  = {tag_q[set_s][victim_d], set_s};
        mem_wdata_d = data_q[set_s][victim_d];
      end
      FILL_REQ: begin
        mem_addr_d  = addr_q;
        mem_wdata_d = '0;
      end
      default: begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end
    endcase
  end

  // Line array next values: install/write, writeback clean, and age update.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    age_d   = age_q;
    if (upd_en_s) begin
      valid_d[set_s][acc_way_s] = 1'b1;
      dirty_d[set_s][acc_way_s] = upd_dirty_s;
      tag_d[set_s][acc_way_s]   = tag_s;
      data_d[set_s][acc_way_s]  = upd_data_s;
    end else if (clean_en_s) begin
      dirty_d[set_s][acc_way_s] = 1'b0;
    end else begin
      dirty_d[set_s] = dirty_q[set_s];
    end
    age_d[set_s] = touch_en_s ? new_age_s : age_q[set_s];
  end

  // State, request latches, line arrays and registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q         <= IDLE;
      wr_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      victim_q        <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_hit_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        age_q[s] <= init_ages();
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
        end
      end
    end else begin
      state_q         <= state_d;
      wr_q            <= wr_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      victim_q        <= victim_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_hit_q      <= resp_hit_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_write_q     <= mem_write_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      tag_q           <= tag_d;
      data_q          <= data_d;
      age_q           <= age_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_hit      = resp_hit_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_write     = mem_write_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;
  logic [15:0] wb_count_q, wb_count_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Hit/miss counted while the response is presented; writebacks on handshake.
  always_comb begin
    hit_count_d  = ((state_q == RESP) && resp_hit_q)  ? sat_inc(hit_count_q)  : hit_count_q;
    miss_count_d = ((state_q == RESP) && !resp_hit_q) ? sat_inc(miss_count_q) : miss_count_q;
    wb_count_d   = ((state_q == WB) && mem_req_ready) ? sat_inc(wb_count_q)   : wb_count_q;
  end

  // Statistics registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hit_count_q  <= 16'd0;
      miss_count_q <= 16'd0;
      wb_count_q   <= 16'd0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
  assign wb_count   = 16'd0;
`endif

endmodule

// File: tb/tb_cache_assoc_wb.sv
// Scoreboard bench for cache_assoc_wb: directed requests push expected
// responses and memory operations; a negedge monitor pops and compares.
module tb_cache_assoc_wb;

  logic        clock, resetn;
  logic        req_valid, req_ready, req_write;
  logic [4:0]  req_addr, req_wdata;
  logic        resp_valid, resp_hit;
  logic [4:0]  resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_write;
  logic [4:0]  mem_addr, mem_wdata;
  logic        mem_rvalid;
  logic [4:0]  mem_rdata;
  logic [15:0] hit_count, miss_count, wb_count;

  typedef struct {
    logic [4:0] rdata;
    logic       hit;
    int         lat;
  } resp_t;

  typedef struct {
    logic       w;
    logic [4:0] addr;
    logic [4:0] wdata;
  } mem_t;

  resp_t resp_q[$];
  mem_t  mem_q[$];
  resp_t mon_r;
  mem_t  mon_m;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int acc_cyc = 0;
  int resp_seen = 0;
  int stall = 0;
  int fill_lat = 1;
  int fill_delay = 0;
  logic fill_pending = 1'b0;
  logic hs_read_armed = 1'b0;
  logic [4:0] fill_data = 5'h00;

  cache_assoc_wb dut (
    .clock         (clock),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_hit      (resp_hit),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .hit_count     (hit_count),
    .miss_count    (miss_count),
    .wb_count      (wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: response and memory-handshake scoreboard, sampled at negedge.
  always @(negedge clock) begin
    ncyc++;
    if (req_valid && req_ready) acc_cyc = ncyc;
    if (resp_valid) begin
      resp_seen++;
      if (resp_q.size() == 0) begin
        fail("unexpected_resp");
      end else begin
        mon_r = resp_q.pop_front();
        chk("resp_rdata", 32'(resp_rdata), 32'(mon_r.rdata));
        chk("resp_hit", 32'(resp_hit), 32'(mon_r.hit));
        if (mon_r.lat >= 0) chk("resp_latency", ncyc - acc_cyc, mon_r.lat);
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      if (mem_q.size() == 0) begin
        fail("unexpected_mem_req");
      end else begin
        mon_m = mem_q.pop_front();
        chk("mem_write", 32'(mem_write), 32'(mon_m.w));
        chk("mem_addr", 32'(mem_addr), 32'(mon_m.addr));
        if (mon_m.w) chk("mem_wdata", 32'(mem_wdata), 32'(mon_m.wdata));
      end
    end
  end

  // Memory model: ready with optional stall, read data returned fill_lat later.
  initial begin
    mem_req_ready = 1'b1;
    mem_rvalid    = 1'b0;
    mem_rdata     = 5'h00;
    forever begin
      @(posedge clock);
      #1;
      mem_rvalid = 1'b0;
      if (fill_pending) begin
        if (fill_delay == 0) begin
          mem_rvalid   = 1'b1;
          mem_rdata    = fill_data;
          fill_pending = 1'b0;
        end else begin
          fill_delay--;
        end
      end
      if (hs_read_armed) begin
        fill_pending = 1'b1;
        fill_delay   = fill_lat;
      end
      mem_req_ready = (stall == 0);
      if (stall > 0) stall--;
      hs_read_armed = mem_req_valid && mem_req_ready && !mem_write;
    end
  end

  task automatic push_mem(input logic w, input logic [4:0] a, input logic [4:0] d);
    mem_t m;
    m.w = w; m.addr = a; m.wdata = d;
    mem_q.push_back(m);
  endtask

  task automatic push_resp(input logic [4:0] rd, input logic h, input int lat);
    resp_t r;
    r.rdata = rd; r.hit = h; r.lat = lat;
    resp_q.push_back(r);
  endtask

  task automatic issue_req(input logic w, input logic [4:0] a, input logic [4:0] d);
    int n;
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!req_ready) fail("req_ready_timeout");
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int n;
    n = 0;
    while (resp_seen < target && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (resp_seen < target) fail("resp_timeout");
  endtask

  task automatic do_req(input logic w, input logic [4:0] a, input logic [4:0] d,
                        input logic [4:0] er, input logic eh, input int lat);
    int target;
    push_resp(er, eh, lat);
    target = resp_seen + 1;
    issue_req(w, a, d);
    wait_resp(target);
  endtask

  initial begin
    int n;
    int target;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 5'h00;
    req_wdata = 5'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_counters", 32'({hit_count, miss_count} | 32'(wb_count)), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // Read miss with refill, then a hit with no memory traffic.
    push_mem(1'b0, 5'h04, 5'h00);
    fill_data = 5'h11;
    do_req(1'b0, 5'h04, 5'h00, 5'h11, 1'b0, -1);
    do_req(1'b0, 5'h04, 5'h00, 5'h11, 1'b1, 2);

    // Clean write miss installs directly.
    do_req(1'b1, 5'h06, 5'h1F, 5'h1F, 1'b0, 2);
    do_req(1'b0, 5'h06, 5'h00, 5'h1F, 1'b1, 2);

    // Dirty evictions.
    do_req(1'b1, 5'h02, 5'h0A, 5'h0A, 1'b0, 2);
    push_mem(1'b1, 5'h06, 5'h1F);
    do_req(1'b1, 5'h04, 5'h0C, 5'h0C, 1'b0, -1);
    do_req(1'b0, 5'h02, 5'h00, 5'h0A, 1'b1, 2);
    @(negedge clock);
`ifdef CACHE_STATS_EN
    chk("hit_count", 32'(hit_count), 32'd3);
    chk("miss_count", 32'(miss_count), 32'd4);
    chk("wb_count", 32'(wb_count), 32'd1);
`else
    chk("hit_count", 32'(hit_count), 32'd0);
    chk("miss_count", 32'(miss_count), 32'd0);
    chk("wb_count", 32'(wb_count), 32'd0);
`endif
    push_mem(1'b1, 5'h04, 5'h0C);
    push_mem(1'b0, 5'h08, 5'h00);
    fill_data = 5'h15;
    do_req(1'b0, 5'h08, 5'h00, 5'h15, 1'b0, -1);

    // Refill request held while memory stalls.
    push_mem(1'b0, 5'h03, 5'h00);
    fill_data = 5'h07;
    push_resp(5'h07, 1'b0, -1);
    stall = 10;
    target = resp_seen + 1;
    issue_req(1'b0, 5'h03, 5'h00);
    @(posedge clock);
    #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("stall_mem_req_valid", 32'(mem_req_valid), 32'd1);
      chk("stall_mem_write", 32'(mem_write), 32'd0);
      chk("stall_mem_addr", 32'(mem_addr), 32'h03);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_resp_valid", 32'(resp_valid), 32'd0);
    end
    wait_resp(target);

    // Reset during FILL_WAIT; the late refill data must be ignored.
    push_mem(1'b0, 5'h05, 5'h00);
    fill_lat  = 8;
    fill_data = 5'h1E;
    issue_req(1'b0, 5'h05, 5'h00);
    n = 0;
    while (mem_q.size() != 0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (mem_q.size() != 0) fail("fill_handshake_timeout");
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_counters", 32'({hit_count, miss_count} | 32'(wb_count)), 32'd0);
    repeat (14) @(posedge clock);
    #1;
    @(negedge clock);
    chk("late_rvalid_req_ready", 32'(req_ready), 32'd1);
    chk("late_rvalid_resp_valid", 32'(resp_valid), 32'd0);
    fill_lat  = 1;
    push_mem(1'b0, 5'h05, 5'h00);
    fill_data = 5'h19;
    do_req(1'b0, 5'h05, 5'h00, 5'h19, 1'b0, -1);
    push_mem(1'b0, 5'h03, 5'h00);
    fill_data = 5'h07;
    do_req(1'b0, 5'h03, 5'h00, 5'h07, 1'b0, -1);

    repeat (3) @(posedge clock);
    chk("resp_q_left", resp_q.size(), 32'd0);
    chk("mem_q_left", mem_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
